// File: rtl/param_fifo_pkg.sv
// Shared defaults for param_fifo and its storage sub-module.
package param_fifo_pkg;

  localparam int unsigned DefWidth    = 8;
  localparam int unsigned DefDepth    = 16;
  localparam int unsigned DefAeThresh = 2;
  localparam int unsigned DefFwft     = 0;

endpackage

// File: rtl/param_fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write, asynchronous read, never reset.
module param_fifo_mem
  import param_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO with occupancy/threshold flags, reject pulses and selectable
// registered or first-word-fall-through read port.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = DefWidth,
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = DefAeThresh,
  parameter int unsigned FWFT      = DefFwft
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, underflow_q;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] head;

  // A write into a full FIFO is legal when a read frees the slot on the same edge.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  always_comb begin
    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CW'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_ok) wptr_q <= wptr_q + AW'(1);
      if (rd_ok) rptr_q <= rptr_q + AW'(1);
      count_q     <= count_d;
      overflow_q  <= wr_en && !wr_ok;
      underflow_q <= rd_en && empty;
    end
  end

  param_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wptr_q),
    .wdata (din),
    .raddr (rptr_q),
    .rdata (head)
  );

  if (FWFT != 0) begin : g_fwft
    assign dout = empty ? '0 : head;
  end else begin : g_reg
    logic [WIDTH-1:0] dout_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        dout_q <= '0;
      end else if (rd_ok) begin
        dout_q <= head;
      end
    end
    assign dout = dout_q;
  end

  assign count        = count_q;
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_param_fifo.sv
// Drives a registered-read and a FWFT instance with identical stimulus and checks
// both against a queue-based model every cycle.
module tb_param_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] dout0, dout1;
  logic [4:0] cnt0, cnt1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;

  param_fifo #(.FWFT(0)) u_reg (
    .clk (clk), .reset (reset), .wr_en (wr_en), .rd_en (rd_en), .din (din),
    .dout (dout0), .full (full0), .empty (empty0), .almost_full (af0),
    .almost_empty (ae0), .count (cnt0), .overflow (ovf0), .underflow (unf0)
  );

  param_fifo #(.FWFT(1)) u_fwft (
    .clk (clk), .reset (reset), .wr_en (wr_en), .rd_en (rd_en), .din (din),
    .dout (dout1), .full (full1), .empty (empty1), .almost_full (af1),
    .almost_empty (ae1), .count (cnt1), .overflow (ovf1), .underflow (unf1)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, registered-read output, reject pulses.
  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       m_ovf, m_unf;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int sz;
    logic [7:0] head;
    sz   = q.size();
    head = (sz > 0) ? q[0] : 8'h00;
    check_eq("count0", 32'(cnt0), 32'(sz));
    check_eq("full0", 32'(full0), 32'(sz == 16));
    check_eq("empty0", 32'(empty0), 32'(sz == 0));
    check_eq("afull0", 32'(af0), 32'(sz >= 14));
    check_eq("aempty0", 32'(ae0), 32'(sz <= 2));
    check_eq("ovf0", 32'(ovf0), 32'(m_ovf));
    check_eq("unf0", 32'(unf0), 32'(m_unf));
    check_eq("dout0", 32'(dout0), 32'(m_dout));
    check_eq("count1", 32'(cnt1), 32'(sz));
    check_eq("full1", 32'(full1), 32'(sz == 16));
    check_eq("empty1", 32'(empty1), 32'(sz == 0));
    check_eq("afull1", 32'(af1), 32'(sz >= 14));
    check_eq("aempty1", 32'(ae1), 32'(sz <= 2));
    check_eq("ovf1", 32'(ovf1), 32'(m_ovf));
    check_eq("unf1", 32'(unf1), 32'(m_unf));
    check_eq("dout1", 32'(dout1), 32'(head));
  endtask

  // One clock: apply inputs, advance the model on the edge, check just after it.
  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic rst);
    bit rd_acc, wr_acc;
    wr_en = w;
    rd_en = r;
    din   = d;
    reset = rst;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_dout = 8'h00;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      rd_acc = r && (q.size() > 0);
      wr_acc = w && ((q.size() < 16) || rd_acc);
      m_ovf  = w && !wr_acc;
      m_unf  = r && (q.size() == 0);
      if (rd_acc) m_dout = q.pop_front();
      if (wr_acc) q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    // Fill with FF..F0, then an extra write that must be dropped.
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < 16; i++) step(1, 0, 8'(8'hFF - i), 0);
    step(1, 0, 8'h11, 0);
    step(0, 0, 8'h00, 0);
    // Drain in order, then underflow on empty.
    for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    // Empty with both requests: write only, underflow pulse.
    step(1, 1, 8'h33, 0);
    step(0, 1, 8'h00, 0);
    // Full with both requests, then drain so 0xAA comes out last.
    for (int i = 0; i < 16; i++) step(1, 0, 8'(8'hFF - i), 0);
    step(1, 1, 8'hAA, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0);
    // Mixed traffic across pointer wraps.
    for (int i = 0; i < 40; i++) step(1'($urandom), 1'($urandom), 8'($urandom), 0);
    // Reset mid-operation at count 8 with a write pending.
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 8'(i + 1), 0);
    step(1, 0, 8'hEE, 1);
    step(0, 0, 8'h00, 0);
    // FWFT visibility without rd_en, then read back to empty.
    step(1, 0, 8'h5A, 0);
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'h00, 0);
    // Random phases biased towards filling or draining.
    for (int p = 0; p < 12; p++) begin
      int wp;
      wp = (p % 2 == 0) ? 80 : 25;
      for (int i = 0; i < 50; i++) begin
        step($urandom_range(99) < wp, $urandom_range(99) < (100 - wp),
             8'($urandom), $urandom_range(199) == 0);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
